// File: rtl/shift_sequencer.sv
// Multi-cycle log shifter: one stage per clock, start/busy/done handshake.
// Define SHIFT_ROTATE_EN to enable circular stages via the rot input.
module reversal #(
  parameter int width = 16
) (
  input  logic [width-1:0] a,
  output logic [width-1:0] y
);
  always_comb begin
    y = '0;
    for (int i = 0; i < width; i++)
      y[i] = a[width-1-i];
  end
endmodule

module shift_sequencer #(
  parameter int width = 16,
  parameter int sw    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [sw-1:0]    shamt,
  input  logic             dir,
  input  logic             arith,
  input  logic             rot,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] y
);
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [sw-1:0] klast = sw'(sw-1);
  localparam logic [sw:0]   one   = {{sw{1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [width-1:0] work, a_rev, work_rev, stage, hi;
  logic [sw-1:0]    k, shamt_q, sel;
  logic [sw:0]      amt;
  logic [2*width-1:0] ext;
  logic             dir_q, arith_q, fill;
`ifdef SHIFT_ROTATE_EN
  logic             rot_q;
`else
  logic             unused_rot;
  assign unused_rot = rot;
`endif

  reversal #(.width(width)) u_rev_in  (.a(a),    .y(a_rev));
  reversal #(.width(width)) u_rev_out (.a(work), .y(work_rev));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (k == klast) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Fill copies the running MSB so multi-stage arithmetic shifts compose.
  always_comb begin
    amt  = one << k;
    sel  = shamt_q >> k;
`ifdef SHIFT_ROTATE_EN
    fill = arith_q & ~dir_q & ~rot_q;
    hi   = rot_q ? work : {width{fill & work[width-1]}};
`else
    fill = arith_q & ~dir_q;
    hi   = {width{fill & work[width-1]}};
`endif
    ext   = {hi, work} >> amt;
    stage = sel[0] ? ext[width-1:0] : work;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work    <= '0;
      k       <= '0;
      shamt_q <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      rot_q   <= 1'b0;
`endif
      y       <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            work    <= dir ? a_rev : a;
            shamt_q <= shamt;
            dir_q   <= dir;
            arith_q <= arith;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= rot;
`endif
            k       <= '0;
          end
        end
        SHIFT: begin
          work <= stage;
          k    <= k + 1'b1;
        end
        DONE: begin
          y    <= dir_q ? work_rev : work;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (width 16, sw 4).
// Rotate expectations follow SHIFT_ROTATE_EN.
module tb_shift_sequencer;
  localparam int W = 16;

`ifdef SHIFT_ROTATE_EN
  localparam logic [15:0] exp_rr  = 16'hF0F0;
  localparam logic [15:0] exp_rl  = 16'h0003;
  localparam logic [15:0] exp_rar = 16'h4001;
`else
  localparam logic [15:0] exp_rr  = 16'h00F0;
  localparam logic [15:0] exp_rl  = 16'h0002;
  localparam logic [15:0] exp_rar = 16'hC001;
`endif

  logic         clk = 1'b0;
  logic         rst, start, dir, arith, rot;
  logic [W-1:0] a;
  logic [3:0]   shamt;
  logic         busy, done;
  logic [W-1:0] y;
  int           n_chk = 0;
  int           n_fail = 0;
  bit           seen_done;

  always #5 clk = ~clk;

  shift_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .shamt(shamt),
    .dir(dir), .arith(arith), .rot(rot),
    .busy(busy), .done(done), .y(y)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input string tag, input logic [15:0] va,
                        input logic [3:0] vs, input logic vd,
                        input logic vx, input logic vr);
    a = va; shamt = vs; dir = vd; arith = vx; rot = vr;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_on"}, 32'(busy), 32'd1);
    check({tag, ".done_lo"}, 32'(done), 32'd0);
  endtask

  task automatic finish_op(input string tag, input logic [15:0] exp,
                           input int edges);
    int n  = 0;
    int bc = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (busy === 1'b1) bc++;
    end
    check({tag, ".lat"},  32'(n),    32'(edges));
    check({tag, ".busy"}, 32'(bc),   32'(edges - 1));
    check({tag, ".y"},    32'(y),    32'(exp));
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_drop(input string tag);
    @(posedge clk); #1;
    check({tag, ".drop"}, 32'(done), 32'd0);
  endtask

  task automatic op(input string tag, input logic [15:0] va,
                    input logic [3:0] vs, input logic vd, input logic vx,
                    input logic vr, input logic [15:0] exp);
    @(negedge clk);
    launch(tag, va, vs, vd, vx, vr);
    finish_op(tag, exp, 5);
    check_drop(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; shamt = '0;
    dir = 1'b0; arith = 1'b0; rot = 1'b0;
    #12;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.y",    32'(y),    32'd0);
    @(negedge clk) rst = 1'b0;

    op("srl4",  16'h0F0F, 4'd4,  1'b0, 1'b0, 1'b0, 16'h00F0);
    op("sll4",  16'h0F0F, 4'd4,  1'b1, 1'b0, 1'b0, 16'hF0F0);
    op("sra1",  16'h8001, 4'd1,  1'b0, 1'b1, 1'b0, 16'hC000);
    op("srl1",  16'h8001, 4'd1,  1'b0, 1'b0, 1'b0, 16'h4000);
    op("sh0",   16'h1234, 4'd0,  1'b0, 1'b0, 1'b0, 16'h1234);
    op("sll15", 16'h0001, 4'd15, 1'b1, 1'b0, 1'b0, 16'h8000);
    op("sra5",  16'hF000, 4'd5,  1'b0, 1'b1, 1'b0, 16'hFF80);
    op("sra15", 16'h8000, 4'd15, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    op("slla",  16'h8001, 4'd1,  1'b1, 1'b1, 1'b0, 16'h0002);
    op("rotr",  16'h0F0F, 4'd4,  1'b0, 1'b0, 1'b1, exp_rr);
    op("rotl",  16'h8001, 4'd1,  1'b1, 1'b0, 1'b1, exp_rl);
    op("rota",  16'h8002, 4'd1,  1'b0, 1'b1, 1'b1, exp_rar);

    // start during busy is dropped
    @(negedge clk);
    launch("ign", 16'h0F0F, 4'd4, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    a = 16'hFFFF; shamt = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op("ign", 16'h00F0, 3);
    check_drop("ign");

    // start held through the done cycle
    @(negedge clk);
    launch("b2b1", 16'h00FF, 4'd8, 1'b1, 1'b0, 1'b0);
    finish_op("b2b1", 16'hFF00, 5);
    launch("b2b2", 16'h0F0F, 4'd4, 1'b0, 1'b0, 1'b0);
    finish_op("b2b2", 16'h00F0, 5);
    check_drop("b2b2");

    // abort between E2 and E3
    @(negedge clk);
    launch("abort", 16'hF0F0, 4'd4, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.y",    32'(y),    32'd0);
    @(negedge clk) rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort.nodone", 32'(seen_done), 32'd0);
    op("fresh", 16'h1234, 4'd4, 1'b0, 1'b0, 1'b0, 16'h0123);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
